// File: rtl/soc_test_monitor.sv
// rtl/soc_test_monitor.sv - end-of-test checker: watches retires, compares register taps at pass PC
module soc_test_monitor #(
    parameter int XLEN      = 32,
    parameter int NCHK      = 4,
    parameter int TMO_W     = 16,
    parameter int CHECK_DLY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 retire_vld,
    input  logic [XLEN-1:0]      retire_pc,
    input  logic [XLEN-1:0]      pass_pc,
    input  logic [XLEN-1:0]      fail_pc,
    input  logic                 fail_pc_en,
    input  logic [TMO_W-1:0]     timeout_limit,
    input  logic [NCHK*XLEN-1:0] chk_val,
    input  logic [NCHK*XLEN-1:0] chk_exp,
    input  logic [NCHK*2-1:0]    chk_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [NCHK-1:0]      fail_mask,
    output logic [TMO_W-1:0]     cycle_cnt,
    output logic [31:0]          retire_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_CHK  = 2'b01;
    localparam logic [1:0] FC_PC   = 2'b10;
    localparam logic [1:0] FC_TMO  = 2'b11;
    localparam logic [2:0] DLY     = 3'(CHECK_DLY);

    state_t          state;
    logic [2:0]      dly_cnt;
    logic [NCHK-1:0] mismatch;
    logic            fail_hit;
    logic            pass_hit;
    logic            tmo_hit;

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NCHK; i++) begin
            case (chk_mode[2*i +: 2])
                2'b01:   mismatch[i] = (chk_val[i*XLEN +: XLEN] != chk_exp[i*XLEN +: XLEN]);
                2'b10:   mismatch[i] = (chk_val[i*XLEN +: XLEN] == chk_exp[i*XLEN +: XLEN]);
                default: mismatch[i] = 1'b0;
            endcase
        end
    end

    assign fail_hit = retire_vld && fail_pc_en && (retire_pc == fail_pc);
    assign pass_hit = retire_vld && (retire_pc == pass_pc);
    assign tmo_hit  = (timeout_limit != '0) && (cycle_cnt == timeout_limit - TMO_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            dly_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= FC_NONE;
            fail_mask  <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_code  <= FC_NONE;
                        fail_mask  <= '0;
                        cycle_cnt  <= '0;
                        retire_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + TMO_W'(1);
                    if (retire_vld && retire_cnt != '1)
                        retire_cnt <= retire_cnt + 32'd1;
                    // fail PC outranks pass PC, and pass PC outranks a same-cycle timeout
                    if (fail_hit) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_PC;
                    end else if (pass_hit) begin
                        state   <= S_WAIT;
                        dly_cnt <= DLY;
                    end else if (tmo_hit) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_TMO;
                    end
                end
                S_WAIT: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + TMO_W'(1);
                    // let writeback of the final instructions land before sampling the taps
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - 3'd1;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (|mismatch) begin
                            fail      <= 1'b1;
                            fail_code <= FC_CHK;
                            fail_mask <= mismatch;
                        end else begin
                            pass <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_test_monitor.sv
// tb/tb_soc_test_monitor.sv - scoreboard bench for soc_test_monitor
module tb_soc_test_monitor;

    localparam int XLEN      = 32;
    localparam int NCHK      = 2;
    localparam int TMO_W     = 16;
    localparam int CHECK_DLY = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 retire_vld;
    logic [XLEN-1:0]      retire_pc;
    logic [XLEN-1:0]      pass_pc;
    logic [XLEN-1:0]      fail_pc;
    logic                 fail_pc_en;
    logic [TMO_W-1:0]     timeout_limit;
    logic [NCHK*XLEN-1:0] chk_val;
    logic [NCHK*XLEN-1:0] chk_exp;
    logic [NCHK*2-1:0]    chk_mode;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic [1:0]           fail_code;
    logic [NCHK-1:0]      fail_mask;
    logic [TMO_W-1:0]     cycle_cnt;
    logic [31:0]          retire_cnt;

    typedef struct {
        logic            pass;
        logic [1:0]      code;
        logic [NCHK-1:0] mask;
        int              dcyc;
        int              ccnt;
        int              rcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic done_q = 1'b0;

    soc_test_monitor #(
        .XLEN(XLEN), .NCHK(NCHK), .TMO_W(TMO_W), .CHECK_DLY(CHECK_DLY)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .retire_vld(retire_vld), .retire_pc(retire_pc),
        .pass_pc(pass_pc), .fail_pc(fail_pc), .fail_pc_en(fail_pc_en),
        .timeout_limit(timeout_limit),
        .chk_val(chk_val), .chk_exp(chk_exp), .chk_mode(chk_mode),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_mask(fail_mask),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every rising edge of done is a verdict and consumes one scoreboard entry
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no verdict", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("v_pass",       pass,       mon_e.pass);
                check("v_fail",       fail,       !mon_e.pass);
                check("v_fail_code",  fail_code,  mon_e.code);
                check("v_fail_mask",  fail_mask,  mon_e.mask);
                check("v_cycle_cnt",  cycle_cnt,  mon_e.ccnt);
                check("v_retire_cnt", retire_cnt, mon_e.rcnt);
                check("v_done_cycle", cyc,        mon_e.dcyc);
                check("v_busy",       busy,       1'b0);
            end
        end
        done_q = done;
    end

    task automatic push_exp(input logic p, input logic [1:0] code, input logic [NCHK-1:0] mask,
                            input int dcyc, input int ccnt, input int rcnt);
        exp_t e;
        e.pass = p; e.code = code; e.mask = mask;
        e.dcyc = dcyc; e.ccnt = ccnt; e.rcnt = rcnt;
        sb.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm_busy",       busy,       1'b1);
        check("arm_done",       done,       1'b0);
        check("arm_cycle_cnt",  cycle_cnt,  0);
        check("arm_retire_cnt", retire_cnt, 0);
        check("arm_fail_code",  fail_code,  0);
        check("arm_fail_mask",  fail_mask,  0);
    endtask

    task automatic retire(input logic [XLEN-1:0] pc);
        retire_vld = 1'b1;
        retire_pc  = pc;
        @(negedge clk);
        retire_vld = 1'b0;
    endtask

    task automatic wait_verdict();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL verdict_timeout: got no done expected %0d verdicts", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_pass"},       pass,       0);
        check({tag, "_fail"},       fail,       0);
        check({tag, "_fail_code"},  fail_code,  0);
        check({tag, "_fail_mask"},  fail_mask,  0);
        check({tag, "_cycle_cnt"},  cycle_cnt,  0);
        check({tag, "_retire_cnt"}, retire_cnt, 0);
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        retire_vld    = 1'b0;
        retire_pc     = '0;
        pass_pc       = 32'h58;
        fail_pc       = 32'h100;
        fail_pc_en    = 1'b1;
        timeout_limit = '0;
        chk_exp       = {32'd8, 32'd5};
        chk_mode      = 4'b10_01;
        chk_val       = {32'd3, 32'd5};
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;

        // pass after three ordinary retires
        do_start();
        chk_val = {32'd3, 32'd5};
        retire(32'h10); retire(32'h14); retire(32'h18);
        push_exp(1'b1, 2'b00, 2'b00, cyc + 3, 6, 4);
        retire(32'h58);
        wait_verdict();

        // not-equal channel sees equal value
        do_start();
        chk_val = {32'd8, 32'd5};
        push_exp(1'b0, 2'b01, 2'b10, cyc + 3, 3, 1);
        retire(32'h58);
        wait_verdict();

        // timeout, with a start pulse mid-run that must be ignored
        timeout_limit = 16'h115;
        do_start();
        push_exp(1'b0, 2'b11, 2'b00, cyc + 16'h115, 16'h115, 0);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_verdict();
        repeat (3) @(negedge clk);
        check("tmo_hold_cycle_cnt", cycle_cnt, 16'h115);
        check("tmo_hold_done",      done,      1'b1);
        timeout_limit = '0;

        // fail PC equal to pass PC
        pass_pc = 32'h40;
        fail_pc = 32'h40;
        do_start();
        push_exp(1'b0, 2'b10, 2'b00, cyc + 1, 1, 1);
        retire(32'h40);
        wait_verdict();

        // same PCs with fail matching disabled: checks decide
        fail_pc_en = 1'b0;
        chk_val    = {32'd3, 32'd5};
        do_start();
        push_exp(1'b1, 2'b00, 2'b00, cyc + 3, 3, 1);
        retire(32'h40);
        wait_verdict();

        // pass PC on the timeout cycle wins over timeout
        fail_pc_en    = 1'b1;
        fail_pc       = 32'h100;
        pass_pc       = 32'h58;
        timeout_limit = 16'd10;
        chk_val       = {32'd3, 32'd4};
        do_start();
        repeat (9) @(negedge clk);
        push_exp(1'b0, 2'b01, 2'b01, cyc + 3, 12, 1);
        retire(32'h58);
        wait_verdict();
        timeout_limit = '0;

        // reset during WAIT
        do_start();
        retire(32'h58);
        check("wait_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all_zero("midrst");
        repeat (6) @(negedge clk);
        check("midrst_no_done", done, 1'b0);

        // re-arm from IDLE after reset
        chk_val = {32'd3, 32'd5};
        do_start();
        push_exp(1'b1, 2'b00, 2'b00, cyc + 3, 3, 1);
        retire(32'h58);
        wait_verdict();

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
